eth_mac_pause_ctrl_tx: RTL
==========================

// Module: eth_mac_pause_ctrl_tx
// PURPOSE
//  802.3x flow-control stage on the 8-bit AXI-stream TX path, ahead of the 1G MAC TX input.
//  Passes user frames through and, on request, inserts a 60-byte MAC PAUSE frame.
//  Holds off new user frames while a received PAUSE quanta timer is running.
//  Timer tracks byte times in both GMII and MII (clk_enable / mii_select) modes.
// PARAMETERS
//  DATA_WIDTH        8        stream width; only 8 supported
//  USER_WIDTH        1        tuser width; bit 0 = bad-frame marker
//  QUANTUM_BYTES     64       byte times per pause quantum (512 bit times)
//  PAUSE_FRAME_LEN   60       inserted frame length before FCS; zero padded
// PORTS
//  clk                  in   1      clock
//  rst_n                in   1      asynchronous reset, active low
//  s_axis_tdata         in   8      user frame data
//  s_axis_tvalid/tlast  in   1      user frame handshake and end of frame
//  s_axis_tready        out  1      user frame ready
//  s_axis_tuser         in   USER_WIDTH  user sideband
//  m_axis_tdata         out  8      to MAC TX
//  m_axis_tvalid/tlast  out  1      to MAC TX
//  m_axis_tready        in   1      from MAC TX
//  m_axis_tuser         out  USER_WIDTH  to MAC TX; all-zero on inserted frames
//  rx_pause_valid       in   1      1-cycle pulse: PAUSE received (already in clk domain)
//  rx_pause_quanta      in   16     quanta carried by the received PAUSE
//  tx_pause_req         in   1      1-cycle pulse: send PAUSE
//  tx_pause_quanta      in   16     quanta to advertise
//  cfg_src_mac          in   48     SA of inserted frame
//  clk_enable           in   1      byte/nibble qualifier
//  mii_select           in   1      1 = MII, 2 enabled cycles per byte
//  paused               out  1      pause timer non-zero
//  pause_sent           out  1      1-cycle pulse on last beat of inserted frame
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; timers 0; pending request cleared.
//  Reset mid-frame aborts immediately; no tlast is issued.
//  States: IDLE, PASS, PAUSE_TX. Arbitration happens only in IDLE.
//  IDLE -> PAUSE_TX when a PAUSE request is pending; this has priority over user data.
//  IDLE -> PASS when s_axis_tvalid=1 and paused=0. Otherwise stay in IDLE.
//  While in IDLE, s_axis_tready=0 and m_axis_tvalid=0.
//  PASS: combinational pass-through, zero latency.
//   - m_axis_* = s_axis_*; s_axis_tready = m_axis_tready.
//   - Returns to IDLE on the accepted beat with tlast=1.
//   - A pause that starts mid-frame never truncates the frame.
//  PAUSE_TX: drives a byte counter 0..59; advances on m_axis_tvalid & m_axis_tready; tvalid stays high.
//   - Bytes 0-5:   01 80 C2 00 00 01
//   - Bytes 6-11:  cfg_src_mac, MSB first
//   - Bytes 12-13: 88 08
//   - Bytes 14-15: 00 01
//   - Bytes 16-17: latched quanta, MSB first
//   - Bytes 18-59: 00
//   - tlast on byte 59; pause_sent pulses the same cycle; then IDLE.
//  Pending request: tx_pause_req sets pending and latches tx_pause_quanta.
//   - A later request before the frame starts overwrites the quanta (latest wins).
//   - Entering PAUSE_TX clears pending.
//   - A request during PAUSE_TX stays pending for a new frame.
//  Inserted PAUSE frames ignore paused; MAC control frames are exempt from pause.
//  Byte tick:
//   - clk_enable && !mii_select, or
//   - clk_enable && mii_select && phase=1, where phase toggles on each enabled cycle and clears when mii_select=0.
//  Timer is pause_cnt[15:0] plus sub_cnt counting 0..QUANTUM_BYTES-1 on byte ticks.
//  At the sub_cnt wrap, pause_cnt decrements; it saturates at 0.
//  rx_pause_valid loads pause_cnt=rx_pause_quanta and sub_cnt=0; it overrides any tick in the same cycle.
//  Quanta 0 resumes immediately.
//  paused = (pause_cnt != 0), registered.
// TESTING
//  1. Single 64B user frame, tready=1, no pause -> output identical, zero latency, tlast on beat 64.
//  2. tx_pause_req with quanta=0x1234 and SA 02:00:00:00:00:01 while idle.
//     -> 60 beats, bytes 16-17 = 12 34, pause_sent on beat 60.
//  3. Request during a user frame, then a second request with 0x0002 before the frame ends.
//     -> user frame completes intact; one PAUSE follows carrying 00 02.
//  4. rx_pause_valid quanta=2 in GMII mode with clk_enable=1.
//     -> paused stays high 128 cycles; user tvalid is blocked, then the frame passes.
//  5. Same as 4 but MII with clk_enable every cycle -> paused lasts 256 cycles.
//     A quanta=0 reload midway -> paused falls the next cycle.
//  6. rst_n low mid PAUSE_TX -> outputs 0 asynchronously.
//     After release, state is IDLE and no stale pending request remains.

Source files
------------

// File: rtl/eth_mac_pause_ctrl_tx.sv
// eth_mac_pause_ctrl_tx: 802.3x flow control on the 8-bit TX stream.
// Inserts MAC PAUSE frames on request and holds off user frames while a received pause runs.
module eth_mac_pause_ctrl_tx #(
    parameter int DATA_WIDTH      = 8,
    parameter int USER_WIDTH      = 1,
    parameter int QUANTUM_BYTES   = 64,
    parameter int PAUSE_FRAME_LEN = 60
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  rx_pause_valid,
    input  logic [15:0]           rx_pause_quanta,
    input  logic                  tx_pause_req,
    input  logic [15:0]           tx_pause_quanta,
    input  logic [47:0]           cfg_src_mac,
    input  logic                  clk_enable,
    input  logic                  mii_select,
    output logic                  paused,
    output logic                  pause_sent
);
    localparam int BW = $clog2(PAUSE_FRAME_LEN);
    localparam int SW = QUANTUM_BYTES > 1 ? $clog2(QUANTUM_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, PASS, PAUSE_TX} state_t;
    state_t state, state_next;

    logic [BW-1:0] byte_cnt;
    logic          pending;
    logic [15:0]   req_quanta, frame_quanta;
    logic          phase, byte_tick, sub_wrap, last_byte, start_pause;
    logic [15:0]   pause_cnt, pause_next;
    logic [SW-1:0] sub_cnt, sub_next;
    logic [143:0]  hdr, hdr_sh;

    assign start_pause = (state == IDLE) && pending;
    assign last_byte   = byte_cnt == BW'(PAUSE_FRAME_LEN - 1);
    // Header bytes shift out MSB first; past byte 17 the shift empties the vector, giving the zero pad.
    assign hdr         = {48'h0180_C200_0001, cfg_src_mac, 32'h8808_0001, frame_quanta};
    assign hdr_sh      = hdr << {byte_cnt, 3'b000};
    assign byte_tick   = clk_enable && (!mii_select || phase);
    assign sub_wrap    = sub_cnt == SW'(QUANTUM_BYTES - 1);

    always_comb begin
        state_next    = state;
        s_axis_tready = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        pause_sent    = 1'b0;
        case (state)
            IDLE: state_next = pending ? PAUSE_TX : (s_axis_tvalid && !paused) ? PASS : IDLE;
            PASS: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                s_axis_tready = m_axis_tready;
                state_next    = (s_axis_tvalid && m_axis_tready && s_axis_tlast) ? IDLE : PASS;
            end
            PAUSE_TX: begin
                m_axis_tdata  = DATA_WIDTH'(hdr_sh[143:136]);
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = last_byte;
                pause_sent    = last_byte && m_axis_tready;
                state_next    = (last_byte && m_axis_tready) ? IDLE : PAUSE_TX;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            pending      <= 1'b0;
            req_quanta   <= '0;
            frame_quanta <= '0;
        end else begin
            state   <= state_next;
            pending <= tx_pause_req || (pending && !start_pause);
            if (state == PAUSE_TX && m_axis_tready)
                byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            if (tx_pause_req)
                req_quanta <= tx_pause_quanta;
            if (start_pause)
                frame_quanta <= req_quanta;
        end
    end

    // A load from a received PAUSE wins over any byte tick in the same cycle.
    always_comb begin
        pause_next = pause_cnt;
        sub_next   = sub_cnt;
        if (rx_pause_valid) begin
            pause_next = rx_pause_quanta;
            sub_next   = '0;
        end else if (byte_tick && pause_cnt != '0) begin
            sub_next   = sub_wrap ? '0 : sub_cnt + 1'b1;
            pause_next = sub_wrap ? pause_cnt - 1'b1 : pause_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= 1'b0;
            pause_cnt <= '0;
            sub_cnt   <= '0;
            paused    <= 1'b0;
        end else begin
            phase     <= mii_select && (phase ^ clk_enable);
            pause_cnt <= pause_next;
            sub_cnt   <= sub_next;
            paused    <= pause_next != '0;
        end
    end
endmodule
